// File: rtl/mvmf_pkg.sv
// Shared types and constants for the 3x3 motion-vector median filter.
package mvmf_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SORT,
        S_OUT,
        S_ADV
    } state_t;

    localparam int WIN         = 9;
    localparam int MEDIAN_IDX  = 4;
    localparam int MV_W_DEF    = 9;
    localparam int COORD_W_DEF = 8;

endpackage

// File: rtl/mvmf_median9.sv
// Combinational median of nine signed values via a 19 compare-exchange network.
module mvmf_median9
    import mvmf_pkg::*;
#(
    parameter int MV_W = MV_W_DEF
) (
    input  logic [WIN-1:0][MV_W-1:0] i_v,
    output logic [MV_W-1:0]          o_med
);
    localparam int NCE = 19;
    localparam int CE_A [NCE] = '{1, 4, 7, 0, 3, 6, 1, 4, 7, 0, 5, 4, 3, 1, 2, 4, 4, 6, 4};
    localparam int CE_B [NCE] = '{2, 5, 8, 1, 4, 7, 2, 5, 8, 3, 8, 7, 6, 4, 5, 7, 2, 4, 2};

    logic signed [MV_W-1:0] w_s [WIN];
    logic signed [MV_W-1:0] w_t;

    // Pruned network: only the element landing in slot MEDIAN_IDX is guaranteed ordered.
    always_comb begin
        w_t = '0;
        for (int i = 0; i < WIN; i++) w_s[i] = i_v[i];
        for (int i = 0; i < NCE; i++) begin
            if (w_s[CE_A[i]] > w_s[CE_B[i]]) begin
                w_t          = w_s[CE_A[i]];
                w_s[CE_A[i]] = w_s[CE_B[i]];
                w_s[CE_B[i]] = w_t;
            end
        end
        o_med = w_s[MEDIAN_IDX];
    end

endmodule

// File: rtl/mv_median_filter_p.sv
// Raster-scan 3x3 component-wise median over a buffered block MV field, valid/ack output.
// MVMF_ZERO_BORDER_EN: out-of-frame neighbours read as 0 instead of edge replication.
module mv_median_filter_p
    import mvmf_pkg::*;
#(
    parameter int MV_W    = MV_W_DEF,
    parameter int COORD_W = COORD_W_DEF,
    parameter int DEPTH   = 4096,
    parameter int ADDR_W  = 12
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               enable,
    input  logic               start,
    input  logic [COORD_W-1:0] width,
    input  logic [COORD_W-1:0] height,
    input  logic               mv_wr_en,
    input  logic [ADDR_W-1:0]  mv_wr_addr,
    input  logic [MV_W-1:0]    mv_wr_x,
    input  logic [MV_W-1:0]    mv_wr_y,
    input  logic               Nxt_block_sig,
    output logic [COORD_W-1:0] addr_x0,
    output logic [COORD_W-1:0] addr_y0,
    output logic [MV_W-1:0]    gdata_x,
    output logic [MV_W-1:0]    gdata_y,
    output logic               Gvector_sig,
    output logic               busy,
    output logic               done,
    output logic               err
);
    localparam int PW = 2 * COORD_W;

    state_t                   r_state, w_next;
    logic [COORD_W-1:0]       r_w, r_h, r_bx, r_by, r_ax, r_ay, w_nx, w_ny;
    logic [3:0]               r_cnt;
    logic [1:0]               r_kx, r_ky;
    logic [MV_W-1:0]          r_mem_x [DEPTH];
    logic [MV_W-1:0]          r_mem_y [DEPTH];
    logic [MV_W-1:0]          r_rd_x, r_rd_y, w_cap_x, w_cap_y;
    logic [MV_W-1:0]          w_med_x, w_med_y, r_gx, r_gy;
    logic [WIN-1:0][MV_W-1:0] r_win_x, r_win_y;
    logic [ADDR_W-1:0]        w_addr;
    logic                     w_too_big, w_empty, w_last, w_oob_x, w_oob_y, w_rd_en;
    logic                     w_fetch_rd, r_done, r_err;

    assign w_too_big = (32'(width) * 32'(height)) > 32'(DEPTH);
    assign w_empty   = (width == '0) || (height == '0);
    assign w_last    = (r_bx == r_w - COORD_W'(1)) && (r_by == r_h - COORD_W'(1));

    // Window slot (r_kx, r_ky) maps to offset (kx-1, ky-1); off-frame steps stay on the edge.
    assign w_oob_x = (r_kx == 2'd0 && r_bx == '0) || (r_kx == 2'd2 && r_bx == r_w - COORD_W'(1));
    assign w_oob_y = (r_ky == 2'd0 && r_by == '0) || (r_ky == 2'd2 && r_by == r_h - COORD_W'(1));
    assign w_nx    = w_oob_x ? r_bx : r_bx + COORD_W'(r_kx) - COORD_W'(1);
    assign w_ny    = w_oob_y ? r_by : r_by + COORD_W'(r_ky) - COORD_W'(1);
    assign w_addr  = ADDR_W'(PW'(w_ny) * PW'(r_w) + PW'(w_nx));

    assign w_fetch_rd = enable && (r_state == S_FETCH) && (r_cnt != 4'(WIN));

`ifdef MVMF_ZERO_BORDER_EN
    logic r_rd_zero;
    assign w_rd_en = w_fetch_rd && !(w_oob_x || w_oob_y);
    assign w_cap_x = r_rd_zero ? '0 : r_rd_x;
    assign w_cap_y = r_rd_zero ? '0 : r_rd_y;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset)           r_rd_zero <= 1'b0;
        else if (w_fetch_rd) r_rd_zero <= w_oob_x || w_oob_y;
    end
`else
    assign w_rd_en = w_fetch_rd;
    assign w_cap_x = r_rd_x;
    assign w_cap_y = r_rd_y;
`endif

    always_ff @(posedge CLK) begin
        if (mv_wr_en && r_state == S_IDLE) begin
            r_mem_x[mv_wr_addr] <= mv_wr_x;
            r_mem_y[mv_wr_addr] <= mv_wr_y;
        end
        if (w_rd_en) begin
            r_rd_x <= r_mem_x[w_addr];
            r_rd_y <= r_mem_y[w_addr];
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (enable) begin
            case (r_state)
                S_IDLE:  if (start && !w_too_big && !w_empty) w_next = S_FETCH;
                S_FETCH: if (r_cnt == 4'(WIN)) w_next = S_SORT;
                S_SORT:  w_next = S_OUT;
                S_OUT:   if (Nxt_block_sig) w_next = S_ADV;
                S_ADV:   w_next = w_last ? S_IDLE : S_FETCH;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_w <= '0; r_h <= '0; r_bx <= '0; r_by <= '0;
            r_cnt <= '0; r_kx <= '0; r_ky <= '0;
            r_win_x <= '0; r_win_y <= '0;
            r_gx <= '0; r_gy <= '0; r_ax <= '0; r_ay <= '0;
            r_done <= 1'b0; r_err <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (enable) begin
                case (r_state)
                    S_IDLE: if (start) begin
                        r_w <= width; r_h <= height; r_bx <= '0; r_by <= '0;
                        r_cnt <= '0; r_kx <= '0; r_ky <= '0;
                        if (w_too_big)    r_err  <= 1'b1;
                        else if (w_empty) r_done <= 1'b1;
                    end
                    S_FETCH: begin
                        // Read data lags the issue by one cycle, so slot r_cnt-1 lands now.
                        if (r_cnt != '0) begin
                            r_win_x[r_cnt - 4'd1] <= w_cap_x;
                            r_win_y[r_cnt - 4'd1] <= w_cap_y;
                        end
                        if (r_cnt != 4'(WIN)) begin
                            r_cnt <= r_cnt + 4'd1;
                            r_kx  <= (r_kx == 2'd2) ? 2'd0 : r_kx + 2'd1;
                            r_ky  <= (r_kx == 2'd2) ? r_ky + 2'd1 : r_ky;
                        end
                    end
                    S_SORT: begin
                        r_gx <= w_med_x; r_gy <= w_med_y;
                        r_ax <= r_bx;    r_ay <= r_by;
                    end
                    S_ADV: begin
                        r_cnt <= '0; r_kx <= '0; r_ky <= '0;
                        if (w_last) begin
                            r_done <= 1'b1;
                        end else if (r_bx == r_w - COORD_W'(1)) begin
                            r_bx <= '0;
                            r_by <= r_by + COORD_W'(1);
                        end else begin
                            r_bx <= r_bx + COORD_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    mvmf_median9 #(.MV_W(MV_W)) u_med_x (.i_v(r_win_x), .o_med(w_med_x));
    mvmf_median9 #(.MV_W(MV_W)) u_med_y (.i_v(r_win_y), .o_med(w_med_y));

    assign Gvector_sig = (r_state == S_OUT);
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign err         = r_err;
    assign addr_x0     = r_ax;
    assign addr_y0     = r_ay;
    assign gdata_x     = r_gx;
    assign gdata_y     = r_gy;

endmodule

// File: tb/tb_mv_median_filter_p.sv
// Bench for mv_median_filter_p: sorting-based median model, per-cycle output compare, directed fields.
module tb_mv_median_filter_p;
    localparam int MV_W = 9, COORD_W = 8, ADDR_W = 12;
`ifdef MVMF_ZERO_BORDER_EN
    localparam bit ZB = 1'b1;
`else
    localparam bit ZB = 1'b0;
`endif

    logic               CLK = 1'b0;
    logic               reset, enable, start, mv_wr_en, Nxt_block_sig;
    logic [COORD_W-1:0] width, height, addr_x0, addr_y0;
    logic [ADDR_W-1:0]  mv_wr_addr;
    logic [MV_W-1:0]    mv_wr_x, mv_wr_y, gdata_x, gdata_y;
    logic               Gvector_sig, busy, done, err;

    int n_chk = 0, n_err = 0;
    int fx [16][16];
    int fy [16][16];
    int exp_x[$], exp_y[$], exp_ax[$], exp_ay[$];
    int res_x [256];
    int res_y [256];
    int res_n = 0;

    mv_median_filter_p dut (
        .CLK(CLK), .reset(reset), .enable(enable), .start(start),
        .width(width), .height(height), .mv_wr_en(mv_wr_en), .mv_wr_addr(mv_wr_addr),
        .mv_wr_x(mv_wr_x), .mv_wr_y(mv_wr_y), .Nxt_block_sig(Nxt_block_sig),
        .addr_x0(addr_x0), .addr_y0(addr_y0), .gdata_x(gdata_x), .gdata_y(gdata_y),
        .Gvector_sig(Gvector_sig), .busy(busy), .done(done), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, act, expv);
        end
    endtask

    function automatic int med9(input int v[9]);
        int a[9];
        int t;
        a = v;
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
        return a[4];
    endfunction

    task automatic build_exp(input int w, input int h);
        int vx[9];
        int vy[9];
        int nx, ny;
        exp_x.delete(); exp_y.delete(); exp_ax.delete(); exp_ay.delete();
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++) begin
                for (int k = 0; k < 9; k++) begin
                    nx = x + k % 3 - 1;
                    ny = y + k / 3 - 1;
                    if (ZB && (nx < 0 || nx >= w || ny < 0 || ny >= h)) begin
                        vx[k] = 0; vy[k] = 0;
                    end else begin
                        nx = (nx < 0) ? 0 : ((nx >= w) ? w - 1 : nx);
                        ny = (ny < 0) ? 0 : ((ny >= h) ? h - 1 : ny);
                        vx[k] = fx[ny][nx]; vy[k] = fy[ny][nx];
                    end
                end
                exp_x.push_back(med9(vx)); exp_y.push_back(med9(vy));
                exp_ax.push_back(x);       exp_ay.push_back(y);
            end
    endtask

    task automatic fill(input int vx, input int vy);
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) begin fx[y][x] = vx; fy[y][x] = vy; end
    endtask

    task automatic load_field(input int w, input int h);
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++) begin
                mv_wr_en = 1'b1; mv_wr_addr = ADDR_W'(y * w + x);
                mv_wr_x = MV_W'(fx[y][x]); mv_wr_y = MV_W'(fy[y][x]);
                @(posedge CLK); #1;
            end
        mv_wr_en = 1'b0;
    endtask

    // Result checker: whenever a result is presented it must equal the model's head entry.
    always @(negedge CLK) begin
        if (!reset && Gvector_sig) begin
            if (exp_x.size() == 0) begin
                chk("unexpected_result", 32'(Gvector_sig), 0);
            end else begin
                chk("addr_x0", 32'(addr_x0), exp_ax[0]);
                chk("addr_y0", 32'(addr_y0), exp_ay[0]);
                chk("gdata_x", 32'($signed(gdata_x)), exp_x[0]);
                chk("gdata_y", 32'($signed(gdata_y)), exp_y[0]);
                if (Nxt_block_sig && enable) begin
                    res_x[res_n] = exp_x[0]; res_y[res_n] = exp_y[0]; res_n++;
                    void'(exp_x.pop_front()); void'(exp_y.pop_front());
                    void'(exp_ax.pop_front()); void'(exp_ay.pop_front());
                end
            end
        end
    end

    task automatic run_pass(input int w, input int h, input int bp_blk, input int bp_len,
                            input bit stall, input bit wrs, input int abort_at);
        int t, hold, last_rise, nrise, t_done;
        bit fin, pg;
        build_exp(w, h);
        res_n = 0;
        width = COORD_W'(w); height = COORD_W'(h); start = 1'b1; Nxt_block_sig = 1'b1;
        if (wrs) begin
            mv_wr_en = 1'b1; mv_wr_addr = '0;
            mv_wr_x = MV_W'(fx[0][0]); mv_wr_y = MV_W'(fy[0][0]);
        end
        @(posedge CLK); #1;
        start = 1'b0; mv_wr_en = 1'b0;
        t = 1; fin = 1'b0; hold = 0; last_rise = 0; nrise = 0; pg = 1'b0; t_done = -1;
        while (!fin && t < 5000) begin
            if (t == abort_at) begin
                reset = 1'b1;
                #1;
                chk("rst_gvec", 32'(Gvector_sig), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_done", 32'(done), 0);
                chk("rst_addr_x0", 32'(addr_x0), 0);
                chk("rst_gdata_x", 32'(gdata_x), 0);
                @(posedge CLK); #1;
                reset = 1'b0;
                exp_x.delete(); exp_y.delete(); exp_ax.delete(); exp_ay.delete();
                return;
            end
            enable = !(stall && (t % 5 == 2));
            if (Gvector_sig && !pg) begin
                if (!stall) begin
                    if (nrise == 0) chk("first_latency", t, 12);
                    else chk("block_gap", t - last_rise, (nrise - 1 == bp_blk) ? 13 + bp_len : 13);
                end
                last_rise = t;
                nrise++;
            end
            pg = Gvector_sig;
            if (Gvector_sig && (nrise - 1 == bp_blk) && hold < bp_len) begin
                Nxt_block_sig = 1'b0; hold++;
            end else begin
                Nxt_block_sig = 1'b1;
            end
            if (done) begin fin = 1'b1; t_done = t; end
            @(posedge CLK); #1;
            t++;
        end
        enable = 1'b1;
        chk("done_seen", 32'(fin), 1);
        chk("result_count", res_n, w * h);
        chk("model_drained", exp_x.size(), 0);
        chk("busy_after_done", 32'(busy), 0);
        if (w * h == 0) chk("empty_done_cycle", t_done, 1);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; start = 1'b0; mv_wr_en = 1'b0; Nxt_block_sig = 1'b0;
        width = '0; height = '0; mv_wr_addr = '0; mv_wr_x = '0; mv_wr_y = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_gvec", 32'(Gvector_sig), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_err", 32'(err), 0);
        chk("reset_addr", 32'({addr_x0, addr_y0}), 0);
        chk("reset_gdata", 32'({gdata_x, gdata_y}), 0);
        reset = 1'b0;
        @(posedge CLK); #1;

        // Empty frame: immediate done, no results.
        run_pass(0, 4, -1, 0, 1'b0, 1'b0, -1);

        // Oversized frame is refused.
        width = 8'd65; height = 8'd65; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        chk("reject_err", 32'(err), 1);
        chk("reject_busy", 32'(busy), 0);
        @(posedge CLK); #1;
        chk("reject_err_pulse", 32'(err), 0);
        chk("reject_busy_hold", 32'(busy), 0);

        // Constant field.
        fill(3, -2);
        load_field(4, 4);
        run_pass(4, 4, -1, 0, 1'b0, 1'b0, -1);
        chk("const_mid_x", res_x[5], 3);
        chk("const_mid_y", res_y[5], -2);

        // Backpressure on block (1,0).
        run_pass(4, 4, 1, 20, 1'b0, 1'b0, -1);

        // Impulse suppression.
        fill(0, 0);
        fx[2][2] = 100; fy[2][2] = -100;
        load_field(5, 5);
        run_pass(5, 5, -1, 0, 1'b0, 1'b0, -1);
        chk("impulse_x", res_x[12], 0);
        chk("impulse_y", res_y[12], 0);

        // Corner outlier.
        fill(1, 1);
        fx[0][0] = 7; fy[0][0] = 7;
        load_field(3, 3);
        run_pass(3, 3, -1, 0, 1'b0, 1'b0, -1);
        chk("corner_x", res_x[0], ZB ? 0 : 1);
        chk("corner_y", res_y[0], ZB ? 0 : 1);

        // Mixed-sign non-square field, periodic stalls, write coinciding with start.
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) begin
                fx[y][x] = (x * 37 + y * 11) % 41 - 20;
                fy[y][x] = 15 - (x * 13 + y * 29) % 31;
            end
        load_field(5, 3);
        fx[0][0] = -77; fy[0][0] = 90;
        run_pass(5, 3, -1, 0, 1'b1, 1'b1, -1);

        // Reset during a pass, then a clean rerun from block (0,0).
        fill(3, -2);
        fx[1][1] = -50; fy[1][2] = 60; fx[3][0] = 9;
        load_field(4, 4);
        run_pass(4, 4, -1, 0, 1'b0, 1'b0, 45);
        run_pass(4, 4, -1, 0, 1'b0, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
